// File: rtl/bram_sum_loader.sv
// bram_sum_loader: walks NUM_WORDS addresses of two ROM BRAMs and writes douta+doutb per address into a FIFO.
// Defining BRAM_SUM_SAT_EN makes the sum saturate at 2**OUT_W-1 instead of wrapping.
module bram_sum_loader #(
    parameter int ADDR_W    = 4,
    parameter int A_W       = 4,
    parameter int B_W       = 5,
    parameter int OUT_W     = 5,
    parameter int NUM_WORDS = 10,
    parameter int BRAM_LAT  = 1
) (
    input  logic              fclk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [A_W-1:0]    douta,
    input  logic [B_W-1:0]    doutb,
    output logic [OUT_W-1:0]  fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic              busy,
    output logic              done,
    output logic              ovf
);
    localparam int SUM_W = (A_W > B_W ? A_W : B_W) + 1;
    localparam int CMP_W = SUM_W > OUT_W ? SUM_W : OUT_W + 1;
    localparam int CNT_W = $clog2(BRAM_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [OUT_W-1:0]  r_din, w_din_nxt, w_red;
    logic              r_ovf, w_ovf_nxt, w_sum_ovf;
    logic [CNT_W-1:0]  r_wait, w_wait_nxt;
    logic [CMP_W-1:0]  w_sum;

    // Sum is at least one bit wider than the output so overflow is always visible.
    assign w_sum     = CMP_W'(douta) + CMP_W'(doutb);
    assign w_sum_ovf = |(w_sum >> OUT_W);
`ifdef BRAM_SUM_SAT_EN
    assign w_red = w_sum_ovf ? '1 : w_sum[OUT_W-1:0];
`else
    assign w_red = w_sum[OUT_W-1:0];
`endif

    assign addr       = r_addr;
    assign fifo_din   = r_din;
    assign ovf        = r_ovf;
    assign fifo_wr_en = (r_state == S_WRITE) && !fifo_full;
    assign busy       = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);

    always_ff @(posedge fclk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_din   <= '0;
            r_ovf   <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_din   <= w_din_nxt;
            r_ovf   <= w_ovf_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_ovf_nxt   = r_ovf;
        w_wait_nxt  = r_wait;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_addr_nxt  = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_wait_nxt  = CNT_W'(BRAM_LAT);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait == CNT_W'(1)) begin
                    w_din_nxt   = w_red;
                    w_ovf_nxt   = r_ovf | w_sum_ovf;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_wait_nxt = r_wait - CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (!fifo_full) begin
                    if (r_addr == ADDR_W'(NUM_WORDS - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                w_addr_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_bram_sum_loader.sv
// tb_bram_sum_loader: directed bench for bram_sum_loader (default build and BRAM_LAT=2/NUM_WORDS=16 instance).
module tb_bram_sum_loader;
    logic       fclk = 1'b0, reset = 1'b0, start = 1'b0, fifo_full = 1'b0;
    logic [3:0] addr, douta;
    logic [4:0] doutb, fifo_din;
    logic       fifo_wr_en, busy, done, ovf;
    logic       start2 = 1'b0, full2 = 1'b0;
    logic [3:0] addr2, douta2, pa;
    logic [4:0] doutb2, din2, pb;
    logic       wr2, busy2, done2, ovf2;

    logic [3:0] a_mem [16];
    logic [4:0] b_mem [16];
    int cyc = 0, n_cmp = 0, n_err = 0;
    int done_cnt = 0, done_t = 0, done_cnt2 = 0, done_t2 = 0, full_wr = 0;
    logic [4:0] wq[$], wq2[$];
    logic [3:0] wa2[$];
    int wt[$], wt2[$];

    bram_sum_loader dut (
        .fclk(fclk), .reset(reset), .start(start), .addr(addr), .douta(douta), .doutb(doutb),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .busy(busy), .done(done), .ovf(ovf)
    );

    bram_sum_loader #(.NUM_WORDS(16), .BRAM_LAT(2)) dut2 (
        .fclk(fclk), .reset(reset), .start(start2), .addr(addr2), .douta(douta2), .doutb(doutb2),
        .fifo_din(din2), .fifo_wr_en(wr2), .fifo_full(full2),
        .busy(busy2), .done(done2), .ovf(ovf2)
    );

    always #5 fclk = ~fclk;
    always @(posedge fclk) cyc <= cyc + 1;

    always @(posedge fclk) begin
        douta  <= a_mem[addr];
        doutb  <= b_mem[addr];
        pa     <= a_mem[addr2];
        pb     <= b_mem[addr2];
        douta2 <= pa;
        doutb2 <= pb;
    end

    always @(negedge fclk) begin
        if (fifo_wr_en) begin
            wq.push_back(fifo_din);
            wt.push_back(cyc);
            if (fifo_full) full_wr++;
        end
        if (done) begin
            done_cnt++;
            done_t = cyc;
        end
        if (wr2) begin
            wq2.push_back(din2);
            wt2.push_back(cyc);
            wa2.push_back(addr2);
        end
        if (done2) begin
            done_cnt2++;
            done_t2 = cyc;
        end
    end

    task automatic clr();
        wq.delete(); wt.delete(); wq2.delete(); wt2.delete(); wa2.delete();
        done_cnt = 0; done_cnt2 = 0;
    endtask

    task automatic go(output int k);
        @(posedge fclk); #1 start = 1'b1;
        @(posedge fclk); #1 k = cyc; start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge fclk); #1; end
    endtask

    task automatic wait_done(input int k);
        while (done_cnt == 0 && cyc < k + 200) begin @(posedge fclk); #1; end
        n_cmp++;
        if (done_cnt != 1) begin n_err++; $display("FAIL done_seen: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge fclk);
        @(negedge fclk);
        n_cmp++;
        if ({addr, fifo_din, fifo_wr_en, busy, done, ovf} !== 13'd0) begin
            n_err++; $display("FAIL reset_outs: got %b want 0", {addr, fifo_din, fifo_wr_en, busy, done, ovf});
        end
        n_cmp++;
        if ({addr2, din2, wr2, busy2, done2, ovf2} !== 13'd0) begin
            n_err++; $display("FAIL reset_outs2: got %b want 0", {addr2, din2, wr2, busy2, done2, ovf2});
        end
        @(posedge fclk); #1 reset = 1'b1;
    endtask

    task automatic test_basic();
        int k;
        clr(); go(k);
        @(negedge fclk);
        n_cmp++;
        if ({busy, addr, fifo_wr_en} !== 6'b1_0000_0) begin
            n_err++; $display("FAIL basic_issue: got %b want 100000", {busy, addr, fifo_wr_en});
        end
        wait_done(k);
        n_cmp++;
        if (wq.size() != 10) begin n_err++; $display("FAIL basic_count: got %0d want 10", wq.size()); end
        for (int i = 0; i < wq.size(); i++) begin
            n_cmp++;
            if (wq[i] !== 5'(3 * i) || wt[i] - k + 1 != 3 + 3 * i) begin
                n_err++;
                $display("FAIL basic_word[%0d]: got %0d@%0d want %0d@%0d", i, wq[i], wt[i] - k + 1, 3 * i, 3 + 3 * i);
            end
        end
        n_cmp++;
        if (done_t - k + 1 != 31) begin n_err++; $display("FAIL basic_done_time: got %0d want 31", done_t - k + 1); end
        n_cmp++;
        if ({ovf, busy} !== 2'b00) begin n_err++; $display("FAIL basic_ovf_busy: got %b want 00", {ovf, busy}); end
    endtask

    task automatic test_ovf();
        int k;
        logic [4:0] w5, ex;
`ifdef BRAM_SUM_SAT_EN
        w5 = 5'd31;
`else
        w5 = 5'd14;
`endif
        a_mem[5] = 4'd15; b_mem[5] = 5'd31;
        clr(); go(k); wait_done(k);
        n_cmp++;
        if (wq.size() != 10) begin n_err++; $display("FAIL ovf_count: got %0d want 10", wq.size()); end
        for (int i = 0; i < wq.size(); i++) begin
            ex = (i == 5) ? w5 : 5'(3 * i);
            n_cmp++;
            if (wq[i] !== ex) begin n_err++; $display("FAIL ovf_word[%0d]: got %0d want %0d", i, wq[i], ex); end
        end
        a_mem[5] = 4'd5; b_mem[5] = 5'd10;
        repeat (3) @(negedge fclk);
        n_cmp++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        clr(); go(k);
        @(negedge fclk);
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        wait_done(k);
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clean_run: got %b want 0", ovf); end
    endtask

    task automatic test_stall();
        int k;
        clr(); full_wr = 0; go(k);
        wait_until(k + 11);
        fifo_full = 1'b1;
        repeat (5) begin
            @(negedge fclk);
            n_cmp++;
            if ({fifo_wr_en, busy, fifo_din} !== {2'b01, 5'd9}) begin
                n_err++; $display("FAIL stall_hold: got wr=%b busy=%b din=%0d want 0 1 9", fifo_wr_en, busy, fifo_din);
            end
            @(posedge fclk); #1;
        end
        fifo_full = 1'b0;
        wait_done(k);
        n_cmp++;
        if (wq.size() != 10) begin n_err++; $display("FAIL stall_count: got %0d want 10", wq.size()); end
        for (int i = 0; i < wq.size(); i++) begin
            n_cmp++;
            if (wq[i] !== 5'(3 * i)) begin n_err++; $display("FAIL stall_word[%0d]: got %0d want %0d", i, wq[i], 3 * i); end
        end
        n_cmp++;
        if (done_t - k + 1 != 36) begin n_err++; $display("FAIL stall_done_time: got %0d want 36", done_t - k + 1); end
        n_cmp++;
        if (full_wr != 0) begin n_err++; $display("FAIL stall_write_while_full: got %0d want 0", full_wr); end
    endtask

    task automatic test_reset_mid();
        int k;
        clr(); go(k);
        wait_until(k + 12);
        n_cmp++;
        if (wq.size() != 4) begin n_err++; $display("FAIL rmid_pre_count: got %0d want 4", wq.size()); end
        reset = 1'b0;
        @(posedge fclk); #1 reset = 1'b1;
        @(negedge fclk);
        n_cmp++;
        if ({addr, fifo_din, fifo_wr_en, busy, done, ovf} !== 13'd0) begin
            n_err++; $display("FAIL rmid_outs: got %b want 0", {addr, fifo_din, fifo_wr_en, busy, done, ovf});
        end
        repeat (40) @(posedge fclk);
        #1;
        n_cmp++;
        if (wq.size() != 4 || done_cnt != 0) begin
            n_err++; $display("FAIL rmid_no_more: got %0d writes %0d done want 4 0", wq.size(), done_cnt);
        end
        clr(); go(k); wait_done(k);
        n_cmp++;
        if (wq.size() != 10) begin n_err++; $display("FAIL rmid_rerun_count: got %0d want 10", wq.size()); end
        for (int i = 0; i < wq.size(); i++) begin
            n_cmp++;
            if (wq[i] !== 5'(3 * i)) begin n_err++; $display("FAIL rmid_word[%0d]: got %0d want %0d", i, wq[i], 3 * i); end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        clr(); go(k);
        wait_until(k + 5);
        start = 1'b1;
        @(posedge fclk); #1 start = 1'b0;
        wait_until(k + 30);
        start = 1'b1;
        @(negedge fclk);
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_pulse: got %b want 1", done); end
        @(posedge fclk); #1 start = 1'b0;
        wait_until(k + 80);
        n_cmp++;
        if (wq.size() != 10 || done_cnt != 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_ignored: got %0d writes %0d done busy=%b want 10 1 0", wq.size(), done_cnt, busy);
        end
    endtask

    task automatic test_lat2();
        int k, e;
        logic [4:0] ex;
        clr();
        @(posedge fclk); #1 start2 = 1'b1;
        @(posedge fclk); #1 k = cyc; start2 = 1'b0;
        while (done_cnt2 == 0 && cyc < k + 300) begin @(posedge fclk); #1; end
        n_cmp++;
        if (wq2.size() != 16 || done_cnt2 != 1) begin
            n_err++; $display("FAIL lat2_count: got %0d writes %0d done want 16 1", wq2.size(), done_cnt2);
        end
        for (int i = 0; i < wq2.size(); i++) begin
            e = 3 * i;
`ifdef BRAM_SUM_SAT_EN
            ex = e > 31 ? 5'd31 : 5'(e);
`else
            ex = 5'(e);
`endif
            n_cmp++;
            if (wq2[i] !== ex || wa2[i] !== 4'(i) || wt2[i] - k + 1 != 4 + 4 * i) begin
                n_err++;
                $display("FAIL lat2_word[%0d]: got %0d a%0d @%0d want %0d a%0d @%0d", i, wq2[i], wa2[i], wt2[i] - k + 1, ex, i, 4 + 4 * i);
            end
        end
        n_cmp++;
        if (done_t2 - k + 1 != 65) begin n_err++; $display("FAIL lat2_done_time: got %0d want 65", done_t2 - k + 1); end
        @(negedge fclk);
        n_cmp++;
        if ({addr2, busy2, ovf2} !== {4'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL lat2_end: got addr=%0d busy=%b ovf=%b want 0 0 1", addr2, busy2, ovf2);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 4'(i);
            b_mem[i] = 5'(2 * i);
        end
        test_reset();
        test_basic();
        test_ovf();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_lat2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
